// File: rtl/clk_pkg.sv
// Shared definitions for the clock divider: FSM state encoding, parameter
// defaults and the rule that forces degenerate ratios up to the minimum.
package clk_pkg;

    localparam int RATIO_W_DEF       = 8;
    localparam int DEFAULT_RATIO_DEF = 2;
    localparam int MIN_RATIO         = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    // Ratios of 0 and 1 cannot produce a two-phase clock, so they run as 2.
    function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio);
        return (ratio < 32'(MIN_RATIO)) ? 32'(MIN_RATIO) : ratio;
    endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Period counter for the clock divider: counts 0..ratio-1 while enabled,
// wraps to 0 and flags the wrap (period boundary) combinationally.
module clk_div_counter
    import clk_pkg::*;
#(
    parameter int RATIO_W = RATIO_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               count_en_i,
    input  logic               clear_i,
    input  logic [RATIO_W-1:0] ratio_i,
    output logic [RATIO_W-1:0] cnt_next_o,
    output logic               wrap_o
);

    localparam logic [RATIO_W-1:0] ONE = RATIO_W'(1);

    logic [RATIO_W-1:0] cnt_q;
    logic [RATIO_W-1:0] cnt_d;

    assign wrap_o = count_en_i && (cnt_q == ratio_i - ONE);

    always_comb begin
        // NOTE: default first, so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_next_o = cnt_d;

    cnt_in_range: assert property (@(posedge clk_i) disable iff (!rst_n)
        cnt_q < ratio_i);

endmodule

// File: rtl/clk_divider.sv
// Programmable clock divider: IDLE/RUN/STOP control, glitch-free registered
// clk_out, and ratio changes that only ever take effect on a period boundary.
module clk_divider
    import clk_pkg::*;
#(
    parameter int RATIO_W       = RATIO_W_DEF,
    parameter int DEFAULT_RATIO = DEFAULT_RATIO_DEF
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               en,
    input  logic [RATIO_W-1:0] div_ratio,
    input  logic               load,
    output logic               clk_out,
    output logic               busy,
    output logic               ratio_ack,
    output logic [RATIO_W-1:0] cur_ratio
);

    localparam logic [RATIO_W-1:0] RESET_RATIO =
        RATIO_W'(clamp_ratio(32'(RATIO_W'(DEFAULT_RATIO))));

    state_e             state_q;
    logic               clk_out_q;
    logic               busy_q;

    logic [RATIO_W-1:0] cur_ratio_q,  cur_ratio_d;
    logic [RATIO_W-1:0] pend_ratio_q, pend_ratio_d;
    logic               pend_q,       pend_d;
    logic               ack_q,        ack_d;

    logic               active;
    logic               wrap;
    logic               in_high;
    logic [RATIO_W-1:0] cnt_next;
    logic [RATIO_W-1:0] load_ratio;

    assign active     = (state_q != ST_IDLE);
    assign load_ratio = RATIO_W'(clamp_ratio(32'(div_ratio)));

    clk_div_counter #(
        .RATIO_W (RATIO_W)
    ) u_counter (
        .clk_i      (clk_in),
        .rst_n      (rst_n),
        .count_en_i (active),
        .clear_i    (!active),
        .ratio_i    (cur_ratio_q),
        .cnt_next_o (cnt_next),
        .wrap_o     (wrap)
    );

    // High phase covers cnt 0..(N>>1)-1; the wrap edge always lands at cnt 0.
    assign in_high = (cnt_next < (cur_ratio_q >> 1));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            clk_out_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q   <= ST_RUN;
                        clk_out_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    clk_out_q <= in_high;
                    if (!en) begin
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (en) begin
                        state_q   <= ST_RUN;
                        clk_out_q <= in_high;
                    end else if (wrap) begin
                        state_q   <= ST_IDLE;
                        clk_out_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else begin
                        clk_out_q <= in_high;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    clk_out_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // A load on the wrap edge bypasses the pending register; otherwise the
    // pending value waits for a wrap, or the next edge when idle.
    always_comb begin
        cur_ratio_d  = cur_ratio_q;
        pend_d       = pend_q;
        pend_ratio_d = pend_ratio_q;
        ack_d        = 1'b0;
        if (load && wrap) begin
            cur_ratio_d = load_ratio;
            pend_d      = 1'b0;
            ack_d       = 1'b1;
        end else begin
            if (pend_q && (wrap || !active)) begin
                cur_ratio_d = pend_ratio_q;
                pend_d      = 1'b0;
                ack_d       = 1'b1;
            end
            if (load) begin
                pend_d       = 1'b1;
                pend_ratio_d = load_ratio;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cur_ratio_q <= RESET_RATIO;
            pend_q      <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            cur_ratio_q <= cur_ratio_d;
            pend_q      <= pend_d;
            ack_q       <= ack_d;
        end
    end

    // NOTE: pend_ratio_q is only meaningful while pend_q is set, so it is a
    // plain data register with no reset.
    always_ff @(posedge clk_in) begin
        pend_ratio_q <= pend_ratio_d;
    end

    assign clk_out   = clk_out_q;
    assign busy      = busy_q;
    assign ratio_ack = ack_q;
    assign cur_ratio = cur_ratio_q;

    clk_out_implies_busy: assert property (@(posedge clk_in) disable iff (!rst_n)
        clk_out_q |-> busy_q);

endmodule

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider: a waveform-queue reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_clk_divider;

    localparam int RW        = 8;
    localparam int DEF_RATIO = 2;
    localparam int WAIT_MAX  = 600;

    logic          clk_in    = 1'b0;
    logic          rst_n     = 1'b1;
    logic          en        = 1'b0;
    logic          load      = 1'b0;
    logic [RW-1:0] div_ratio = '0;
    logic          clk_out;
    logic          busy;
    logic          ratio_ack;
    logic [RW-1:0] cur_ratio;

    int n_checks = 0;
    int n_fail   = 0;

    clk_divider #(
        .RATIO_W       (RW),
        .DEFAULT_RATIO (DEF_RATIO)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .div_ratio (div_ratio),
        .load      (load),
        .clk_out   (clk_out),
        .busy      (busy),
        .ratio_ack (ratio_ack),
        .cur_ratio (cur_ratio)
    );

    initial forever #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the current period is a queue of the clk_out values
    // still to come (front = this cycle). A boundary is the last entry.
    bit m_active;
    bit m_stopping;
    bit m_pend;
    bit m_ack;
    bit m_bnd;
    bit m_used;
    int m_ratio;
    int m_pend_val;
    int m_next;
    bit m_wave[$];

    function automatic int clampr(input int r);
        return (r < 2) ? 2 : r;
    endfunction

    task automatic start_period(input int n);
        m_wave.delete();
        for (int i = 0; i < n; i++) m_wave.push_back(i < n / 2);
    endtask

    task automatic model_reset();
        m_active   = 1'b0;
        m_stopping = 1'b0;
        m_pend     = 1'b0;
        m_pend_val = 0;
        m_ack      = 1'b0;
        m_ratio    = clampr(DEF_RATIO);
        m_wave.delete();
    endtask

    task automatic model_step();
        m_bnd  = m_active && (m_wave.size() == 1);
        m_used = 1'b0;
        m_ack  = 1'b0;
        m_next = m_ratio;
        if (m_bnd && load) begin
            m_next = clampr(int'(div_ratio));
            m_ack  = 1'b1;
            m_pend = 1'b0;
            m_used = 1'b1;
        end else if (m_pend && (m_bnd || !m_active)) begin
            m_next = m_pend_val;
            m_ack  = 1'b1;
            m_pend = 1'b0;
        end
        if (load && !m_used) begin
            m_pend     = 1'b1;
            m_pend_val = clampr(int'(div_ratio));
        end
        m_ratio = m_next;
        if (!m_active) begin
            if (en) begin
                m_active   = 1'b1;
                m_stopping = 1'b0;
                start_period(m_next);
            end
        end else begin
            void'(m_wave.pop_front());
            if (m_bnd && m_stopping && !en) begin
                m_active = 1'b0;
                m_wave.delete();
            end else begin
                m_stopping = !en;
                if (m_bnd) start_period(m_next);
            end
        end
    endtask

    initial forever begin
        @(posedge clk_in or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
    end

    initial forever begin
        @(negedge clk_in);
        check("model_clk_out", clk_out,
              (m_active && m_wave.size() > 0) ? m_wave[0] : 1'b0);
        check("model_busy", busy, m_active);
        check("model_ratio_ack", ratio_ack, m_ack);
        check("model_cur_ratio", cur_ratio, m_ratio);
    end

    task automatic load_ratio(input int v);
        div_ratio = RW'(v);
        load      = 1'b1;
        @(negedge clk_in);
        load      = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        bit found = 1'b0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            if (ratio_ack) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        check(name, found, 1'b1);
    endtask

    task automatic sync_rise(input string name);
        bit   found = 1'b0;
        logic prev;
        prev = clk_out;
        for (int i = 0; i < WAIT_MAX; i++) begin
            @(negedge clk_in);
            if (!prev && clk_out) begin
                found = 1'b1;
                break;
            end
            prev = clk_out;
        end
        check(name, found, 1'b1);
    endtask

    task automatic measure(output int hi, output int lo);
        hi = 0;
        lo = 0;
        for (int i = 0; i < WAIT_MAX && clk_out; i++) begin
            hi++;
            @(negedge clk_in);
        end
        for (int i = 0; i < WAIT_MAX && !clk_out; i++) begin
            lo++;
            @(negedge clk_in);
        end
    endtask

    logic [15:0] g_clk;
    logic [15:0] g_busy;
    logic [15:0] g_ack;
    int          h;
    int          l;
    int          acks;

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        check("rst_clk_out",   clk_out,   1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_ratio_ack", ratio_ack, 1'b0);
        check("rst_cur_ratio", cur_ratio, 2);
        rst_n = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        check("idle_clk_out", clk_out, 1'b0);

        // N=2: first rise one edge after en, then toggles every edge.
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            g_clk[5-i]  = clk_out;
            g_busy[5-i] = busy;
        end
        check("n2_wave", g_clk[5:0],  6'b101010);
        check("n2_busy", g_busy[5:0], 6'b111111);

        // N=5 and N=4 duty cycles.
        load_ratio(5);
        wait_ack("ack_n5");
        check("cur_ratio_n5", cur_ratio, 5);
        sync_rise("sync_n5");
        measure(h, l);
        check("n5_high", h, 2);
        check("n5_low",  l, 3);
        measure(h, l);
        check("n5_high_again", h, 2);
        check("n5_low_again",  l, 3);
        load_ratio(4);
        wait_ack("ack_n4");
        sync_rise("sync_n4");
        measure(h, l);
        check("n4_high", h, 2);
        check("n4_low",  l, 2);

        // Running N=4, load 6 while cnt=1: this period finishes with 4, then 6.
        sync_rise("sync_n4_switch");
        g_clk = '0;
        g_ack = '0;
        g_clk[11] = clk_out;
        g_ack[11] = ratio_ack;
        @(negedge clk_in);
        g_clk[10] = clk_out;
        g_ack[10] = ratio_ack;
        div_ratio = 8'd6;
        load      = 1'b1;
        for (int i = 2; i < 12; i++) begin
            @(negedge clk_in);
            load       = 1'b0;
            g_clk[11-i] = clk_out;
            g_ack[11-i] = ratio_ack;
        end
        check("switch_wave", g_clk[11:0], 12'b110011100011);
        check("switch_ack",  g_ack[11:0], 12'b000010000000);
        check("switch_cur",  cur_ratio, 6);

        // N=8, en dropped at cnt=0: full period completes, then idle.
        load_ratio(8);
        wait_ack("ack_n8");
        sync_rise("sync_n8_stop");
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk_in);
            g_clk[9-i]  = clk_out;
            g_busy[9-i] = busy;
        end
        check("stop_wave", g_clk[9:0],  10'b1111000000);
        check("stop_busy", g_busy[9:0], 10'b1111111100);

        // Re-assert en while stopping: no gap in the output.
        en = 1'b1;
        sync_rise("sync_restart");
        en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk_in);
            if (i == 3) en = 1'b1;
            g_clk[15-i]  = clk_out;
            g_busy[15-i] = busy;
        end
        check("resume_wave", g_clk,  16'b1111000011110000);
        check("resume_busy", g_busy, 16'hFFFF);

        // Degenerate ratios run as 2; two loads before a boundary, latest wins.
        load_ratio(0);
        wait_ack("ack_r0");
        check("clamp_r0", cur_ratio, 2);
        load_ratio(1);
        wait_ack("ack_r1");
        check("clamp_r1", cur_ratio, 2);
        load_ratio(8);
        wait_ack("ack_r8");
        check("cur_ratio_r8", cur_ratio, 8);
        sync_rise("sync_double");
        div_ratio = 8'd3;
        load      = 1'b1;
        @(negedge clk_in);
        div_ratio = 8'd7;
        @(negedge clk_in);
        load = 1'b0;
        acks = 0;
        for (int i = 0; i < 14; i++) begin
            acks += int'(ratio_ack);
            @(negedge clk_in);
        end
        check("double_load_acks", acks, 1);
        check("double_load_cur",  cur_ratio, 7);

        // Reset in the middle of a high phase with a ratio pending.
        load_ratio(6);
        wait_ack("ack_r6");
        sync_rise("sync_reset");
        @(negedge clk_in);
        load_ratio(4);
        check("pre_reset_high", clk_out, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_clk_out",   clk_out,   1'b0);
        check("async_rst_busy",      busy,      1'b0);
        check("async_rst_ratio_ack", ratio_ack, 1'b0);
        check("async_rst_cur_ratio", cur_ratio, 2);
        @(negedge clk_in);
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            acks += int'(ratio_ack);
        end
        check("pending_lost_acks", acks, 0);
        check("pending_lost_cur",  cur_ratio, 2);

        // Random traffic against the reference model.
        en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_in);
            load = 1'b0;
            if ($urandom_range(0, 24) == 0) en = ~en;
            if ($urandom_range(0, 5) == 0) begin
                load      = 1'b1;
                div_ratio = ($urandom_range(0, 9) == 0) ? RW'($urandom_range(0, 255))
                                                        : RW'($urandom_range(0, 12));
            end
            if (c == 1000 || c == 2200) begin
                #3 rst_n = 1'b0;
                load = 1'b0;
                @(negedge clk_in);
                @(negedge clk_in);
                rst_n = 1'b1;
            end
        end
        @(negedge clk_in);
        load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/clk_divider.md
CLK_DIVIDER -- requirements
Module: clk_divider

Interface
REQ-001 SHALL have parameter RATIO_W, default 8: width of the divide-ratio field.
REQ-002 SHALL have parameter DEFAULT_RATIO, default 2: divide ratio in force after reset.
REQ-003 SHALL have port clk_in, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1: run request; high starts division, low requests a stop.
REQ-006 SHALL have port div_ratio, input, RATIO_W: requested divide ratio N.
REQ-007 SHALL have port load, input, 1: one-cycle strobe that captures div_ratio.
REQ-008 SHALL have port clk_out, output, 1: registered divided clock, which feeds the downstream clock buffer.
REQ-009 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-010 SHALL have port ratio_ack, output, 1: one-cycle pulse in the cycle a new ratio takes effect.
REQ-011 SHALL have port cur_ratio, output, RATIO_W: the ratio currently in force.

Function
REQ-012 SHALL implement three states:
- IDLE: clk_out=0, cnt held at 0.
- RUN: counting.
- STOP: finishing the current period before halting.
REQ-013 SHALL transition IDLE->RUN on the edge where en=1; at that edge cnt=0 and clk_out=1, so latency from en sampled to the first clk_out rise is one edge.
REQ-014 SHALL, in RUN, count cnt 0..N-1 and wrap to 0; registered clk_out=1 iff the new cnt < (N>>1).
- Even N: exact 50% duty.
- Odd N: the high phase is one cycle shorter than the low phase.
REQ-015 SHALL define a period boundary as the edge where cnt==N-1 in RUN or STOP.
REQ-016 SHALL move RUN->STOP when en=0 is sampled; it SHALL never truncate a high or low phase.
REQ-017 SHALL move STOP->IDLE at the next period boundary (clk_out ends 0).
REQ-018 SHALL, in STOP, return to RUN without interruption if en=1 is sampled before the boundary.
REQ-019 SHALL treat any captured ratio below 2 (0 or 1) as 2.
REQ-020 SHALL capture div_ratio on load into a pending register and set a pending flag; a second load before application overwrites the pending value (latest wins).
REQ-021 SHALL apply the pending ratio:
- at the next period boundary in RUN/STOP;
- on the edge after capture when in IDLE.
On application, cur_ratio updates, the pending flag clears and ratio_ack pulses for one cycle.
REQ-022 SHALL, when load coincides with a period boundary, apply div_ratio directly at that boundary (bypass), with ratio_ack in the following cycle.
REQ-023 SHALL make the new ratio govern the period starting at cnt=0 immediately after application; no period uses a mix of old and new ratios.
REQ-024 SHALL limit cnt width to RATIO_W; no overflow is possible since cnt<=N-1<=2^RATIO_W-2.
REQ-025 SHALL drive all outputs from flops; clk_out SHALL be glitch-free.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force:
- state=IDLE, cnt=0, clk_out=0, busy=0;
- ratio_ack=0, pending flag=0;
- cur_ratio=DEFAULT_RATIO (clamped per REQ-019).
REQ-027 SHALL on reset mid-period drop clk_out to 0 immediately and discard any pending ratio; release is synchronous to the first rising clk_in after rst_n rises.

Structure
REQ-028 SHALL take the state enum (IDLE/RUN/STOP), RATIO_W default and DEFAULT_RATIO from a shared package clk_pkg.
REQ-029 SHALL place the cnt counter with wrap and boundary detect in one sub-module, clk_div_counter; the FSM and ratio logic remain in clk_divider.

Verification
REQ-030 The bench SHALL check: reset, en=1, N=2 -> clk_out toggles every clk_in edge, first rise one edge after en; busy=1.
REQ-031 The bench SHALL check: N=5 -> clk_out high 2 and low 3 cycles, repeating; N=4 -> high 2, low 2.
REQ-032 The bench SHALL check: running N=4, load N=6 at cnt=1 -> current period completes with 4 cycles, then periods of 6; ratio_ack pulses once; cur_ratio=6.
REQ-033 The bench SHALL check: en dropped at cnt=0 with N=8 -> clk_out completes high 4 and low 4, then IDLE; busy falls at that boundary; re-assert en in STOP -> no gap.
REQ-034 The bench SHALL check: load div_ratio=0 and then 1 -> cur_ratio=2; two loads before a boundary -> only the latest is applied, with one ratio_ack.
REQ-035 The bench SHALL check: rst_n low mid high-phase -> clk_out=0 without waiting for a clock edge, cur_ratio=DEFAULT_RATIO, pending ratio lost.
